mat_tile_engine: RTL and testbench



---
 rtl/mat_tile_engine.sv | 177 +++++++++++++++++
 tb/tb_mat_tile_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_tile_engine.sv
// N x N tile multiply-accumulate engine: C = A*B + D over a runtime inner dimension K.
// Operands come from three 1-cycle read ports; results leave row by row on the save port.

module mat_tile_row #(
  parameter int N       = 4,
  parameter int ELEM_W  = 16,
  parameter int RIGHT_W = 8,
  parameter int ACC_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [ELEM_W-1:0]    i_a,
  input  logic [N*RIGHT_W-1:0] i_b,
  output logic [N*ACC_W-1:0]   o_acc
);
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic signed [ELEM_W-1:0]   w_b_ext;
    logic signed [2*ELEM_W-1:0] w_prod;
    logic [ACC_W-1:0]           r_acc;

    assign w_b_ext = ELEM_W'($signed(i_b[j*RIGHT_W +: RIGHT_W]));
    // full-width signed product; only the low ACC_W bits enter the wrapping accumulator
    assign w_prod  = (2*ELEM_W)'($signed(i_a)) * (2*ELEM_W)'(w_b_ext);

    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst)      r_acc <= '0;
      else if (i_clr) r_acc <= '0;
      else if (i_en)  r_acc <= r_acc + w_prod[ACC_W-1:0];

    assign o_acc[j*ACC_W +: ACC_W] = r_acc;
  end
endmodule

module mat_tile_engine #(
  parameter int N         = 4,
  parameter int ELEM_W    = 16,
  parameter int RIGHT_W   = 8,
  parameter int ACC_W     = 16,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 8,
  parameter int K_W       = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [K_W-1:0]       i_k_len,
  input  logic [ADDR_W-1:0]    i_base_left,
  input  logic [ADDR_W-1:0]    i_base_right,
  input  logic [ADDR_W-1:0]    i_base_addsrc,
  input  logic [ADDR_W-1:0]    i_base_save,
  output logic [ADDR_W-1:0]    o_rd_addr_left,
  input  logic [N*ELEM_W-1:0]  i_rd_data_left,
  output logic [ADDR_W-1:0]    o_rd_addr_right,
  input  logic [N*RIGHT_W-1:0] i_rd_data_right,
  output logic [ADDR_W-1:0]    o_rd_addr_add,
  input  logic [N*ACC_W-1:0]   i_rd_data_add,
  output logic                 o_wr_en,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [N*ACC_W-1:0]   o_wr_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           o_state
);
  localparam logic [2:0] S_IDLE = 3'd0, S_CALC = 3'd1, S_FLUSH = 3'd2,
                         S_WB   = 3'd3, S_WB_TAIL = 3'd4, S_DONE = 3'd5;
  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [2:0]                 r_state;
  logic [K_W-1:0]             r_klen, r_k;
  logic [ROW_W-1:0]           r_row;
  logic [ADDR_W-1:0]          r_base_add, r_save_ptr;
  logic [N*ELEM_W-1:0]        r_a;
  logic [N*RIGHT_W-1:0]       r_b;
  logic                       r_mac_vld;
  logic                       w_accept;
  logic [N-1:0][N*ACC_W-1:0]  w_acc;
  logic [N*ACC_W-1:0]         w_sum;

  assign w_accept = (r_state == S_IDLE) && i_start;

  // row i sees A[i][k] broadcast against the whole B[k] word: one outer-product slice per row
  for (genvar i = 0; i < N; i++) begin : g_row
    mat_tile_row #(.N(N), .ELEM_W(ELEM_W), .RIGHT_W(RIGHT_W), .ACC_W(ACC_W)) u_row (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_accept),
      .i_en  (r_mac_vld),
      .i_a   (r_a[i*ELEM_W +: ELEM_W]),
      .i_b   (r_b),
      .o_acc (w_acc[i])
    );
  end

  for (genvar j = 0; j < N; j++) begin : g_sum
    assign w_sum[j*ACC_W +: ACC_W] = w_acc[r_row][j*ACC_W +: ACC_W]
                                   + i_rd_data_add[j*ACC_W +: ACC_W];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_klen          <= '0;
      r_k             <= '0;
      r_row           <= '0;
      r_base_add      <= '0;
      r_save_ptr      <= '0;
      r_a             <= '0;
      r_b             <= '0;
      r_mac_vld       <= 1'b0;
      o_rd_addr_left  <= '0;
      o_rd_addr_right <= '0;
      o_rd_addr_add   <= '0;
      o_wr_en         <= 1'b0;
      o_wr_addr       <= '0;
      o_wr_data       <= '0;
    end else begin
      o_wr_en   <= 1'b0;
      r_mac_vld <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_klen     <= i_k_len;
          r_base_add <= i_base_addsrc;
          r_save_ptr <= i_base_save;
          r_k        <= '0;
          r_row      <= '0;
          if (i_k_len != '0) begin
            o_rd_addr_left  <= i_base_left;
            o_rd_addr_right <= i_base_right;
            r_state         <= S_CALC;
          end else begin
            o_rd_addr_add <= i_base_addsrc;
            r_state       <= S_WB;
          end
        end
        S_CALC: begin
          // operands for word k are latched here and accumulated next cycle
          r_a       <= i_rd_data_left;
          r_b       <= i_rd_data_right;
          r_mac_vld <= 1'b1;
          if (r_k == r_klen - K_W'(1)) begin
            r_state <= S_FLUSH;
          end else begin
            r_k             <= r_k + K_W'(1);
            o_rd_addr_left  <= o_rd_addr_left + STEP;
            o_rd_addr_right <= o_rd_addr_right + STEP;
          end
        end
        S_FLUSH: begin
          o_rd_addr_add <= r_base_add;
          r_state       <= S_WB;
        end
        S_WB: begin
          o_wr_en    <= 1'b1;
          o_wr_addr  <= r_save_ptr;
          o_wr_data  <= w_sum;
          r_save_ptr <= r_save_ptr + STEP;
          if (r_row == ROW_W'(N-1)) begin
            r_state <= S_WB_TAIL;
          end else begin
            r_row         <= r_row + ROW_W'(1);
            o_rd_addr_add <= o_rd_addr_add + STEP;
          end
        end
        S_WB_TAIL: r_state <= S_DONE;
        S_DONE:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_state = r_state;
endmodule

// File: tb/tb_mat_tile_engine.sv
// Directed bench for mat_tile_engine: scoreboard of expected writes built from a behavioural model.
module tb_mat_tile_engine;
  localparam int N = 4, EW = 16, RW = 8, AW = 16, ADW = 32, KW = 11;

  typedef struct {
    logic [ADW-1:0]  addr;
    logic [N*AW-1:0] data;
    int              cyc;
  } wr_t;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic [ADW-1:0]    b_l = '0, b_r = '0, b_d = '0, b_s = '0;
  logic [ADW-1:0]    ra_l, ra_r, ra_d, wr_addr;
  logic [N*EW-1:0]   rd_l;
  logic [N*RW-1:0]   rd_r;
  logic [N*AW-1:0]   rd_d, wr_data;
  logic              wr_en, busy, done;
  logic [2:0]        state;

  logic [N*EW-1:0]   mem_l [0:63];
  logic [N*RW-1:0]   mem_r [0:63];
  logic [N*AW-1:0]   mem_d [0:63];

  wr_t exp_q[$];
  int  n_vec = 0, n_err = 0, cyc = 0, t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_l = mem_l[ra_l[8:3]];
  assign rd_r = mem_r[ra_r[8:3]];
  assign rd_d = mem_d[ra_d[8:3]];

  mat_tile_engine dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len),
    .i_base_left(b_l), .i_base_right(b_r), .i_base_addsrc(b_d), .i_base_save(b_s),
    .o_rd_addr_left(ra_l), .i_rd_data_left(rd_l),
    .o_rd_addr_right(ra_r), .i_rd_data_right(rd_r),
    .o_rd_addr_add(ra_d), .i_rd_data_add(rd_d),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_state(state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // behavioural model: C = A*B + D with 16-bit wrap, B sign-extended from 8 bits
  task automatic push_exp(input int k, input int bl, input int br, input int bd, input int bs, input int ts);
    logic [N*AW-1:0]   row;
    logic [AW-1:0]     acc;
    logic signed [15:0] a;
    logic signed [7:0]  b;
    int                p, off;
    wr_t               e;
    off = (k > 0) ? k + 2 : 1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int kk = 0; kk < k; kk++) begin
          a = mem_l[bl/8 + kk][i*16 +: 16];
          b = mem_r[br/8 + kk][j*8 +: 8];
          p = int'(a) * int'(b);
          acc = acc + p[15:0];
        end
        row[j*16 +: 16] = acc + mem_d[bd/8 + i][j*16 +: 16];
      end
      e.addr = ADW'(bs + 8*i);
      e.data = row;
      e.cyc  = ts + off + i;
      exp_q.push_back(e);
    end
  endtask

  // returns in the first cycle after the sampling edge (label T+1)
  task automatic issue(input int k, input int bl, input int br, input int bd, input int bs, input bit push);
    @(posedge clk); #1;
    k_len = KW'(k); b_l = ADW'(bl); b_r = ADW'(br); b_d = ADW'(bd); b_s = ADW'(bs);
    start = 1'b1;
    t0 = cyc + 1;
    if (push) push_exp(k, bl, br, bd, bs, t0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("state_first", 64'(state), (k > 0) ? 64'd1 : 64'd3);
  endtask

  task automatic wait_done(input int lat0, input int exp_lat);
    int lat;
    lat = lat0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_fall", 64'(busy), 64'd0);
  endtask

  task automatic run(input int k, input int bl, input int br, input int bd, input int bs);
    issue(k, bl, br, bd, bs, 1'b1);
    wait_done(1, (k > 0) ? k + N + 3 : N + 2);
  endtask

  initial forever begin
    wr_t e;
    @(negedge clk);
    if (wr_en) begin
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_write observed addr=%h expected no write", wr_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", wr_data, e.data);
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [ADW-1:0] a0;
    for (int w = 0; w < 64; w++) begin
      mem_l[w] = '0; mem_r[w] = '0; mem_d[w] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_addr_l", 64'(ra_l), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    rst = 1'b0;

    // identity A, B rows 1..16, D=0
    for (int k = 0; k < N; k++) begin
      mem_l[k] = 64'(1) << (k*16);
      for (int j = 0; j < N; j++) mem_r[8+k][j*8 +: 8] = 8'(4*k + j + 1);
    end
    run(4, 0, 64, 128, 1024);

    // K=0: result is D, left address untouched
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mem_d[24+i][j*16 +: 16] = 16'(4*i + j + 1);
    a0 = ra_l;
    run(0, 256, 256, 192, 2048);
    chk("k0_addr_left_hold", 64'(ra_l), 64'(a0));

    // sign extension: 2 * -1 over K=3
    for (int k = 0; k < 3; k++) begin
      mem_l[32+k] = {4{16'h0002}};
      mem_r[32+k] = {4{8'hFF}};
    end
    run(3, 256, 256, 320, 2304);

    // wrap: 0x7FFF * 0x7F twice, plus 1
    for (int k = 0; k < 2; k++) begin
      mem_l[48+k] = {4{16'h7FFF}};
      mem_r[48+k] = {4{8'h7F}};
    end
    for (int i = 0; i < N; i++) mem_d[52+i] = {4{16'h0001}};
    run(2, 384, 384, 416, 2560);
    chk("model_wrap_row", 64'(wr_data), {4{16'hFF03}});
    chk("model_sign_spot", 64'(mem_l[32][15:0]), 64'h0002);

    // second start while busy is ignored
    issue(4, 0, 64, 128, 4096, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    k_len = KW'(2); b_l = ADW'(384); b_r = ADW'(384); b_d = ADW'(416); b_s = ADW'(6000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(4, 4 + N + 3);

    // reset mid-run, then a fresh command on random data
    issue(8, 0, 64, 128, 8192, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_addr_l", 64'(ra_l), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      mem_l[56+k] = {$urandom, $urandom};
      mem_r[56+k] = $urandom;
    end
    for (int i = 0; i < N; i++) mem_d[56+i] = {$urandom, $urandom};
    run(5, 448, 448, 448, 12288);

    repeat (4) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
